dec_multi: RTL and testbench

- Multi-channel, runtime-configurable decimator; next generation of the team's fixed-ratio pick-last decimator.
- Sits between an ADC/DDC sample stream and downstream FFT/measurement logic.
- Adds per-block averaging with saturation, first/last pick modes, a programmable ratio applied glitch-free at block boundaries, and an external phase re-sync.

---
 rtl/dec_multi.sv | 167 ++++++++++++++++
 tb/tb_dec_multi.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dec_multi.sv
// rtl/dec_multi.sv - multi-channel runtime-configurable decimator (pick-last/pick-first/average)
//
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   i_valid      input sample strobe shared by all channels
//   i_data       CH_NUM packed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_sync       restarts the block phase and applies any pending config
//   cfg_load     one-cycle pulse capturing cfg_div/cfg_mode/cfg_shift as pending config
//   cfg_div      decimation ratio (0 and 1 mean 1, values above MAX_DIV clamp)
//   cfg_mode     0/3 pick last, 1 average, 2 pick first
//   cfg_shift    arithmetic right shift applied to the block sum in average mode
//   o_valid      one-cycle strobe, one cycle after the last sample of a block
//   o_data       decimated samples, same packing as i_data, held between strobes
//   o_sat        per-channel clip flag for average mode, held between strobes
module dec_multi #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_NUM     = 2,
  parameter int MAX_DIV    = 1024,
  parameter int DEF_DIV    = 10,
  parameter int DIV_W      = $clog2(MAX_DIV) + 1,
  parameter int ACC_W      = DATA_WIDTH + $clog2(MAX_DIV)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  input  logic [CH_NUM*DATA_WIDTH-1:0] i_data,
  input  logic                         i_sync,
  input  logic                         cfg_load,
  input  logic [DIV_W-1:0]             cfg_div,
  input  logic [1:0]                   cfg_mode,
  input  logic [4:0]                   cfg_shift,
  output logic                         o_valid,
  output logic [CH_NUM*DATA_WIDTH-1:0] o_data,
  output logic [CH_NUM-1:0]            o_sat
);

  localparam logic [1:0] MODE_AVG   = 2'd1;
  localparam logic [1:0] MODE_FIRST = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Ratios are stored already normalised to 1..MAX_DIV.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    if (d <= DIV_W'(1)) return DIV_W'(1);
    if (d > DIV_W'(MAX_DIV)) return DIV_W'(MAX_DIV);
    return d;
  endfunction

  logic [DIV_W-1:0] act_n, pend_n, new_n, cnt;
  logic [1:0]       act_mode, pend_mode, new_mode;
  logic [4:0]       act_shift, pend_shift, new_shift;
  logic             pend_valid;
  logic             first_s, last_s, apply;

  // Config that governs the next block: a load in the same cycle beats the
  // stored pending value, which beats the current active value.
  always_comb begin
    new_n     = act_n;
    new_mode  = act_mode;
    new_shift = act_shift;
    if (cfg_load) begin
      new_n     = eff_div(cfg_div);
      new_mode  = cfg_mode;
      new_shift = cfg_shift;
    end else if (pend_valid) begin
      new_n     = pend_n;
      new_mode  = pend_mode;
      new_shift = pend_shift;
    end
  end

  // A sync sample always opens a new block and never closes the old one.
  assign first_s = i_valid & (i_sync | (cnt == '0));
  assign last_s  = i_valid & ~i_sync & (cnt == act_n - DIV_W'(1));
  assign apply   = i_sync | last_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_n      <= DIV_W'(DEF_DIV);
      act_mode   <= 2'd0;
      act_shift  <= 5'd0;
      pend_n     <= DIV_W'(DEF_DIV);
      pend_mode  <= 2'd0;
      pend_shift <= 5'd0;
      pend_valid <= 1'b0;
    end else if (apply) begin
      act_n      <= new_n;
      act_mode   <= new_mode;
      act_shift  <= new_shift;
      pend_valid <= 1'b0;
    end else if (cfg_load) begin
      pend_n     <= eff_div(cfg_div);
      pend_mode  <= cfg_mode;
      pend_shift <= cfg_shift;
      pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (i_sync) begin
      // The sync sample is sample 0 of the new block under the new ratio.
      cnt <= (i_valid && new_n != DIV_W'(1)) ? DIV_W'(1) : '0;
    end else if (i_valid) begin
      cnt <= last_s ? '0 : cnt + DIV_W'(1);
    end
  end

  logic [CH_NUM*DATA_WIDTH-1:0] sel_data;
  logic [CH_NUM-1:0]            sel_sat;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] x;
    logic signed [ACC_W-1:0]      xs, acc, sum, shifted;
    logic [DATA_WIDTH-1:0]        hold, avg_val;
    logic                         sat_hi, sat_lo;

    assign x  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign xs = {{(ACC_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};

    // On a first sample the old accumulator is ignored so the next block
    // starts immediately, with no idle cycle after the previous one.
    assign sum     = (first_s ? '0 : acc) + xs;
    assign shifted = sum >>> act_shift;
    assign sat_hi  = shifted > SAT_MAX;
    assign sat_lo  = shifted < SAT_MIN;
    assign avg_val = sat_hi ? SAT_MAX[DATA_WIDTH-1:0] :
                     sat_lo ? SAT_MIN[DATA_WIDTH-1:0] :
                              shifted[DATA_WIDTH-1:0];

    assign sel_data[k*DATA_WIDTH +: DATA_WIDTH] =
      (act_mode == MODE_AVG)   ? avg_val :
      (act_mode == MODE_FIRST) ? (first_s ? x : hold) :
                                 x;
    assign sel_sat[k] = (act_mode == MODE_AVG) & (sat_hi | sat_lo);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc  <= '0;
        hold <= '0;
      end else begin
        if (i_valid)     acc <= sum;
        else if (i_sync) acc <= '0;
        if (first_s)     hold <= x;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= '0;
    end else begin
      o_valid <= last_s;
      if (last_s) begin
        o_data <= sel_data;
        o_sat  <= sel_sat;
      end
    end
  end

endmodule

// File: tb/tb_dec_multi.sv
// tb/tb_dec_multi.sv - directed self-checking bench for dec_multi
//
// Drives dec_multi with hand-computed vectors: reset defaults, average,
// saturation, pick-first, deferred config, sync, pass-through, gaps,
// ratio clamping and mid-block reset.
module tb_dec_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_sync;
  logic        cfg_load;
  logic [10:0] cfg_div;
  logic [1:0]  cfg_mode;
  logic [4:0]  cfg_shift;
  logic        o_valid;
  logic [31:0] o_data;
  logic [1:0]  o_sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dec_multi #(
    .DATA_WIDTH(16), .CH_NUM(2), .MAX_DIV(1024), .DEF_DIV(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_sync(i_sync), .cfg_load(cfg_load), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode), .cfg_shift(cfg_shift), .o_valid(o_valid),
    .o_data(o_data), .o_sat(o_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, step past the edge, then release pulses.
  task automatic cyc(input logic v, input logic [15:0] d0, input logic [15:0] d1, input logic s);
    i_valid = v;
    i_data  = {d1, d0};
    i_sync  = s;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_sync   = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic load(input logic [10:0] div, input logic [1:0] mode, input logic [4:0] sh,
                      input logic do_sync);
    cfg_load  = 1'b1;
    cfg_div   = div;
    cfg_mode  = mode;
    cfg_shift = sh;
    cyc(1'b0, 16'd0, 16'd0, 1'b0);
    if (do_sync) cyc(1'b0, 16'd0, 16'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_sync = 1'b0;
    cfg_load = 1'b0; cfg_div = '0; cfg_mode = '0; cfg_shift = '0;
    cyc(1'b0, 16'd0, 16'd0, 1'b0);
    cyc(1'b0, 16'd0, 16'd0, 1'b0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_sat", {30'd0, o_sat}, 32'd0);
    rst_n = 1'b1;

    // Reset defaults: N=10 pick last
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 16'(i), 16'(i + 1000), 1'b0);
      check("ramp_valid", {31'd0, o_valid}, {31'd0, (i % 10 == 9)});
      if (i % 10 == 9) begin
        check("ramp_ch0", {16'd0, o_data[15:0]}, 32'(i));
        check("ramp_ch1", {16'd0, o_data[31:16]}, 32'(i + 1000));
        check("ramp_sat", {30'd0, o_sat}, 32'd0);
      end
    end

    // Average N=4 shift 2
    load(11'd4, 2'd1, 5'd2, 1'b1);
    cyc(1'b1, 16'd100, 16'hFFF8, 1'b0);
    cyc(1'b1, 16'd200, 16'hFFF8, 1'b0);
    cyc(1'b1, 16'd300, 16'hFFF8, 1'b0);
    check("avg_early", {31'd0, o_valid}, 32'd0);
    cyc(1'b1, 16'd400, 16'hFFF8, 1'b0);
    check("avg_valid", {31'd0, o_valid}, 32'd1);
    check("avg_data", o_data, {16'hFFF8, 16'd250});
    check("avg_sat", {30'd0, o_sat}, 32'd0);
    // back-to-back block: ch0 12>>>2=3, ch1 -5>>>2=-2
    cyc(1'b1, 16'd1, 16'hFFFF, 1'b0);
    cyc(1'b1, 16'd2, 16'hFFFF, 1'b0);
    cyc(1'b1, 16'd3, 16'hFFFF, 1'b0);
    cyc(1'b1, 16'd6, 16'hFFFE, 1'b0);
    check("avg2_valid", {31'd0, o_valid}, 32'd1);
    check("avg2_data", o_data, {16'hFFFE, 16'd3});

    // Saturation N=2 shift 0
    load(11'd2, 2'd1, 5'd0, 1'b1);
    cyc(1'b1, 16'd30000, 16'h8AD0, 1'b0);
    cyc(1'b1, 16'd30000, 16'h8AD0, 1'b0);
    check("sat_valid", {31'd0, o_valid}, 32'd1);
    check("sat_data", o_data, {16'h8000, 16'h7FFF});
    check("sat_flags", {30'd0, o_sat}, 32'd3);

    // Shift beyond accumulator width: 10 -> 0, -10 -> -1
    load(11'd2, 2'd1, 5'd31, 1'b1);
    cyc(1'b1, 16'd5, 16'hFFFB, 1'b0);
    cyc(1'b1, 16'd5, 16'hFFFB, 1'b0);
    check("bigshift_data", o_data, {16'hFFFF, 16'h0000});
    check("bigshift_sat", {30'd0, o_sat}, 32'd0);

    // Pick first N=3
    load(11'd3, 2'd2, 5'd0, 1'b1);
    cyc(1'b1, 16'd7, 16'd70, 1'b0);
    cyc(1'b1, 16'd8, 16'd80, 1'b0);
    cyc(1'b1, 16'd9, 16'd90, 1'b0);
    check("first_valid", {31'd0, o_valid}, 32'd1);
    check("first_data", o_data, {16'd70, 16'd7});

    // Deferred config: N=10, load N=3 at counter 5
    load(11'd10, 2'd0, 5'd0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(200 + i), 16'd0, 1'b0);
    load(11'd3, 2'd0, 5'd0, 1'b0);
    for (int i = 5; i < 13; i++) begin
      cyc(1'b1, 16'(200 + i), 16'd0, 1'b0);
      check("defer_valid", {31'd0, o_valid}, {31'd0, (i == 9 || i == 12)});
    end
    check("defer_data", {16'd0, o_data[15:0]}, 32'd212);
    // load coinciding with last sample governs the next block (N=2)
    cyc(1'b1, 16'd213, 16'd0, 1'b0);
    cyc(1'b1, 16'd214, 16'd0, 1'b0);
    cfg_load = 1'b1; cfg_div = 11'd2; cfg_mode = 2'd0; cfg_shift = 5'd0;
    cyc(1'b1, 16'd215, 16'd0, 1'b0);
    check("loadlast_old", {31'd0, o_valid}, 32'd1);
    cyc(1'b1, 16'd216, 16'd0, 1'b0);
    check("loadlast_mid", {31'd0, o_valid}, 32'd0);
    cyc(1'b1, 16'd217, 16'd0, 1'b0);
    check("loadlast_new", {31'd0, o_valid}, 32'd1);
    check("loadlast_data", {16'd0, o_data[15:0]}, 32'd217);

    // Sync with valid at counter 7
    load(11'd10, 2'd0, 5'd0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 16'(300 + i), 16'd0, 1'b0);
    cyc(1'b1, 16'd500, 16'd0, 1'b1);
    check("sync_nov", {31'd0, o_valid}, 32'd0);
    for (int i = 1; i < 10; i++) begin
      cyc(1'b1, 16'(500 + i), 16'd0, 1'b0);
      check("sync_valid", {31'd0, o_valid}, {31'd0, (i == 9)});
    end
    check("sync_data", {16'd0, o_data[15:0]}, 32'd509);
    // sync on what would be the last sample wins: no output
    for (int i = 0; i < 9; i++) cyc(1'b1, 16'(600 + i), 16'd0, 1'b0);
    cyc(1'b1, 16'd609, 16'd0, 1'b1);
    check("synclast_nov", {31'd0, o_valid}, 32'd0);
    check("synclast_hold", {16'd0, o_data[15:0]}, 32'd509);
    nv = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 16'(610 + i), 16'd0, 1'b0);
      if (o_valid) nv++;
    end
    check("synclast_count", 32'(nv), 32'd1);
    check("synclast_end", {31'd0, o_valid}, 32'd1);

    // cfg_div=0 is pass-through
    load(11'd0, 2'd0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'(700 + i), 16'(i), 1'b0);
      check("div0_valid", {31'd0, o_valid}, 32'd1);
      check("div0_data", o_data, {16'(i), 16'(700 + i)});
    end
    cyc(1'b0, 16'd0, 16'd0, 1'b0);
    check("div0_idle", {31'd0, o_valid}, 32'd0);

    // Gaps in i_valid: N=4 counts valid samples only
    load(11'd4, 2'd0, 5'd0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      cyc((j % 2 == 0), 16'(800 + j), 16'd0, 1'b0);
      check("gap_valid", {31'd0, o_valid}, {31'd0, (j == 6)});
    end
    check("gap_data", {16'd0, o_data[15:0]}, 32'd806);

    // Ratio above MAX_DIV clamps to 1024
    load(11'd2047, 2'd0, 5'd0, 1'b1);
    nv = 0;
    for (int i = 0; i < 1023; i++) begin
      cyc(1'b1, 16'(i), 16'd0, 1'b0);
      if (o_valid) nv++;
    end
    check("clamp_none", 32'(nv), 32'd0);
    cyc(1'b1, 16'd1023, 16'd0, 1'b0);
    check("clamp_valid", {31'd0, o_valid}, 32'd1);

    // Reset mid-block from AVG mode
    load(11'd4, 2'd1, 5'd0, 1'b1);
    cyc(1'b1, 16'd30000, 16'd1, 1'b0);
    cyc(1'b1, 16'd30000, 16'd1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 16'd5, 16'd5, 1'b0);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_data", o_data, 32'd0);
    check("midrst_sat", {30'd0, o_sat}, 32'd0);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 16'(10 + i), 16'd0, 1'b0);
      if (o_valid) nv++;
    end
    check("midrst_none", 32'(nv), 32'd0);
    cyc(1'b1, 16'd19, 16'd33, 1'b0);
    check("midrst_out", {31'd0, o_valid}, 32'd1);
    check("midrst_odata", o_data, {16'd33, 16'd19});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
